dm_be_store: RTL and testbench
==============================

Name: dm_be_store

Overview:
- Data memory for the MEM stage, placed directly upstream of the load extender.
- Performs byte-enabled stores for sb/sh/sw and does a 1-cycle registered word read.
- Forwards the registered byte offset and opcode, so the extender receives DMOut with the matching Addr/Op in the same cycle.
- Flags misaligned or out-of-range accesses, and zero-fills the array after reset using a clear sequencer.

Parameters:
- ADDR_W, 10, word-address width; the array holds 2^ADDR_W 32-bit words (default 4 KB).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- PC  in  32  PC of the instruction in MEM; used only by the optional feature.
- MemWrite  in  1  store strobe.
- Op  in  6  opcode of the instruction in MEM.
- Addr  in  32  byte address from the ALU.
- WD  in  32  store data from rt.
- DMOut  out  32  registered word read, feeds the extender.
- AddrOut  out  2  registered Addr[1:0].
- OpOut  out  6  registered Op.
- BE  out  4  combinational byte enables of the current store; 0 when no write occurs.
- AdEL  out  1  registered load address error.
- AdES  out  1  registered store address error.
- Busy  out  1  high while the clear sequencer runs; hazard unit stalls on it.

Behaviour:
- Opcodes:
  - Loads: lb 100000, lbu 100100, lh 100001, lhu 100101, lw 100011.
  - Stores: sb 101000, sh 101001, sw 101011.
- Word index = Addr[ADDR_W+1:2]. Out of range = any bit of Addr[31:ADDR_W+2] set.
- Reset (reset==0, asynchronous):
  - state=CLEAR, clr_idx=0.
  - DMOut=0, AddrOut=0, OpOut=0, AdEL=0, AdES=0, Busy=1.
- FSM states CLEAR and RUN:
  - CLEAR: each cycle mem[clr_idx]<=0 and clr_idx++. After writing index 2^ADDR_W-1, go to RUN. Busy falls on that same edge, so clear takes exactly 2^ADDR_W cycles after reset release.
  - CLEAR: stores dropped (BE=0); DMOut/AdEL/AdES held 0; AddrOut/OpOut still track inputs.
  - Reset asserted mid-clear restarts the clear at index 0.
- RUN, stores (MemWrite=1, Op is a store):
  - sw: requires Addr[1:0]==00, BE=1111.
  - sh: requires Addr[0]==0. Addr[1]=0 gives BE=0011 with lanes[15:0]<=WD[15:0]. Addr[1]=1 gives BE=1100 with lanes[31:16]<=WD[15:0].
  - sb: BE=0001<<Addr[1:0]; that lane <=WD[7:0].
  - Misaligned or out of range: BE=0, no write, AdES<=1 next edge.
  - MemWrite=1 with a non-store Op: no write, no flag.
- RUN, reads:
  - Every cycle, DMOut<=mem[word index]. AddrOut<=Addr[1:0], OpOut<=Op.
  - Latency: 1 cycle.
  - Read-during-write to the same word is write-first: DMOut gets the merged new word.
  - Out-of-range read index gives DMOut=0.
- AdEL<=1 when Op is a load and any of:
  - lw with Addr[1:0]!=00.
  - lh/lhu with Addr[0]==1.
  - out of range.
  - Otherwise AdEL<=0.
- AdES/AdEL are one-cycle pulses aligned with DMOut.
- Non-memory opcodes never raise flags.

Optional Feature:
- Macro DM_DISPLAY_EN.
- Defined: on every completed RUN-state write, issue $display("%d@%h: *%h <= %h", $time, PC, {Addr[31:2],2'b00}, merged_word). Dropped or faulting stores print nothing.
- Undefined: no display code is compiled; logic is identical.

Test Plan:
- Release reset with ADDR_W=4 -> Busy stays 1 for exactly 16 cycles, then 0; reading any word returns 0.
- sw Addr=0x8 WD=0x12345678, then lw Addr=0x8 -> DMOut=0x12345678 one cycle later, with AddrOut=00 and OpOut=100011.
- After the sw above, sb Addr=0x9 WD=0xAB then sh Addr=0xA WD=0xCDEF -> BE=0010 then 1100; word becomes 0xCDEFAB78.
- sw Addr=0x6 -> BE=0, AdES pulses 1 for one cycle, word unchanged. lh Addr=0x3 -> AdEL=1. lbu Addr=0x3 -> AdEL=0.
- sw and lw to the same word in the same cycle with WD=0xDEADBEEF -> DMOut=0xDEADBEEF on the next edge (write-first).
- Drop reset low mid-clear at clr_idx=7 -> outputs go to 0 immediately; after release Busy lasts a full 2^ADDR_W cycles.

Source files
------------

// File: rtl/dm_be_store.sv
// MEM-stage data memory: byte-enabled stores, 1-cycle write-first word read, address
// fault flags, post-reset zero-fill sequencer. Optional store trace: DM_DISPLAY_EN.

module dm_be_lane (
  input  logic       en,
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  output logic [7:0] merged
);
  assign merged = en ? new_byte : old_byte;
endmodule

module dm_be_store #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic        MemWrite,
  input  logic [5:0]  Op,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  output logic [31:0] DMOut,
  output logic [1:0]  AddrOut,
  output logic [5:0]  OpOut,
  output logic [3:0]  BE,
  output logic        AdEL,
  output logic        AdES,
  output logic        Busy
);
  localparam logic [5:0] OP_LB  = 6'b100000, OP_LBU = 6'b100100, OP_LH = 6'b100001,
                         OP_LHU = 6'b100101, OP_LW  = 6'b100011,
                         OP_SB  = 6'b101000, OP_SH  = 6'b101001, OP_SW = 6'b101011;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  clr_idx;
  logic [31:0]        mem [2**ADDR_W];

  logic [ADDR_W-1:0]  widx;
  logic               oor, run;
  logic               is_load, is_store, misal_ld, misal_st, st_ok;
  logic [3:0]         be_raw;
  logic [3:0][7:0]    wdata, rd_word, merged;

  assign widx    = Addr[ADDR_W+1:2];
  assign oor     = |Addr[31:ADDR_W+2];
  assign run     = (state == RUN);
  assign rd_word = mem[widx];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    misal_ld = 1'b0;
    misal_st = 1'b0;
    be_raw   = 4'b0000;
    wdata    = WD;
    case (Op)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin is_load = 1'b1; misal_ld = Addr[0]; end
      OP_LW:         begin is_load = 1'b1; misal_ld = |Addr[1:0]; end
      OP_SB: begin
        is_store = 1'b1;
        be_raw   = 4'b0001 << Addr[1:0];
        wdata    = {4{WD[7:0]}};
      end
      OP_SH: begin
        is_store = 1'b1;
        misal_st = Addr[0];
        be_raw   = Addr[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{WD[15:0]}};
      end
      OP_SW: begin
        is_store = 1'b1;
        misal_st = |Addr[1:0];
        be_raw   = 4'b1111;
      end
      default: ;
    endcase
  end

  assign st_ok = run && MemWrite && is_store && !misal_st && !oor;
  assign BE    = st_ok ? be_raw : 4'b0000;

  // Lanes pass the old byte through when disabled, so merged is also the plain read.
  for (genvar l = 0; l < 4; l++) begin : g_lane
    dm_be_lane u_lane (
      .en       (BE[l]),
      .old_byte (rd_word[l]),
      .new_byte (wdata[l]),
      .merged   (merged[l])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_idx <= clr_idx + ADDR_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    if (state == CLEAR) begin
      Busy = 1'b1;
      if (&clr_idx) state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR)  mem[clr_idx] <= '0;
    else if (|BE)        mem[widx]    <= merged;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      DMOut   <= '0;
      AddrOut <= '0;
      OpOut   <= '0;
      AdEL    <= 1'b0;
      AdES    <= 1'b0;
    end else begin
      AddrOut <= Addr[1:0];
      OpOut   <= Op;
      if (run) begin
        DMOut <= oor ? 32'h0 : merged;
        AdEL  <= is_load && (misal_ld || oor);
        AdES  <= MemWrite && is_store && (misal_st || oor);
      end else begin
        DMOut <= '0;
        AdEL  <= 1'b0;
        AdES  <= 1'b0;
      end
    end
  end

`ifdef DM_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (|BE) $display("%d@%h: *%h <= %h", $time, PC, {Addr[31:2], 2'b00}, merged);
  end
`else
  logic unused_pc;
  assign unused_pc = ^PC;
`endif

endmodule

// File: tb/tb_dm_be_store.sv
// Directed bench for dm_be_store (ADDR_W=4): clear sequencer timing, byte-enabled
// stores, write-first reads, fault flags and mid-clear reset.

module tb_dm_be_store;
  localparam int AW = 4;
  localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100, LH = 6'b100001, LHU = 6'b100101,
                         LW = 6'b100011, SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;

  logic        clk, reset, MemWrite, AdEL, AdES, Busy;
  logic [31:0] PC, Addr, WD, DMOut;
  logic [5:0]  Op, OpOut;
  logic [1:0]  AddrOut;
  logic [3:0]  BE;

  int n_cmp = 0;
  int n_err = 0;

  dm_be_store #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .PC(PC), .MemWrite(MemWrite), .Op(Op), .Addr(Addr),
    .WD(WD), .DMOut(DMOut), .AddrOut(AddrOut), .OpOut(OpOut), .BE(BE),
    .AdEL(AdEL), .AdES(AdES), .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mw;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] dm;
    logic [1:0]  ao;
    logic        adel;
    logic        ades;
  } vec_t;

  vec_t vt[20];
  vec_t vpost[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic mw, logic [5:0] op, logic [31:0] addr, logic [31:0] wd,
                              logic [3:0] be, logic [31:0] dm, logic adel, logic ades);
    vec_t v;
    v.mw = mw; v.op = op; v.addr = addr; v.wd = wd; v.be = be; v.dm = dm;
    v.ao = addr[1:0]; v.adel = adel; v.ades = ades;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    MemWrite = v.mw; Op = v.op; Addr = v.addr; WD = v.wd;
    #1 chk({tag, " BE"}, 32'(BE), 32'(v.be));
    @(posedge clk);
    #1;
    chk({tag, " DMOut"},   DMOut,         v.dm);
    chk({tag, " AddrOut"}, 32'(AddrOut),  32'(v.ao));
    chk({tag, " OpOut"},   32'(OpOut),    32'(v.op));
    chk({tag, " AdEL"},    32'(AdEL),     32'(v.adel));
    chk({tag, " AdES"},    32'(AdES),     32'(v.ades));
  endtask

  // Releases reset at a falling edge and checks Busy drops exactly on the 16th rising edge.
  task automatic clear_run(input string tag);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 2**AW; i++) begin
      @(posedge clk);
      #1;
      if (i == 2**AW - 1) chk({tag, " Busy@15"}, 32'(Busy), 32'd1);
      if (i == 2**AW)     chk({tag, " Busy@16"}, 32'(Busy), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b0; MemWrite = 1'b0; Op = '0; Addr = '0; WD = '0; PC = 32'h0000_3000;

    //          mw    op   addr          wd            be       dm            adel  ades
    vt[0]  = mk(1'b0, LW,  32'h0000_0008, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b0);
    vt[1]  = mk(1'b0, LW,  32'h0000_003C, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b0);
    vt[2]  = mk(1'b1, SW,  32'h0000_0008, 32'h12345678, 4'b1111, 32'h12345678, 1'b0, 1'b0);
    vt[3]  = mk(1'b0, LW,  32'h0000_0008, 32'h0,        4'b0000, 32'h12345678, 1'b0, 1'b0);
    vt[4]  = mk(1'b1, SB,  32'h0000_0009, 32'h0000_00AB, 4'b0010, 32'h1234AB78, 1'b0, 1'b0);
    vt[5]  = mk(1'b1, SH,  32'h0000_000A, 32'h0000_CDEF, 4'b1100, 32'hCDEFAB78, 1'b0, 1'b0);
    vt[6]  = mk(1'b0, LW,  32'h0000_0008, 32'h0,        4'b0000, 32'hCDEFAB78, 1'b0, 1'b0);
    vt[7]  = mk(1'b1, SW,  32'h0000_0006, 32'h11111111, 4'b0000, 32'h0,        1'b0, 1'b1);
    vt[8]  = mk(1'b0, LW,  32'h0000_0004, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b0);
    vt[9]  = mk(1'b0, LH,  32'h0000_0003, 32'h0,        4'b0000, 32'h0,        1'b1, 1'b0);
    vt[10] = mk(1'b0, LBU, 32'h0000_0003, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b0);
    vt[11] = mk(1'b1, SW,  32'h0000_000C, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b0);
    vt[12] = mk(1'b0, LW,  32'h0000_0108, 32'h0,        4'b0000, 32'h0,        1'b1, 1'b0);
    vt[13] = mk(1'b1, SW,  32'h0000_0108, 32'h0000_0001, 4'b0000, 32'h0,        1'b0, 1'b1);
    vt[14] = mk(1'b0, LW,  32'h0000_0008, 32'h0,        4'b0000, 32'hCDEFAB78, 1'b0, 1'b0);
    vt[15] = mk(1'b1, LW,  32'h0000_0008, 32'hFFFFFFFF, 4'b0000, 32'hCDEFAB78, 1'b0, 1'b0);
    vt[16] = mk(1'b0, 6'b000000, 32'h0000_0003, 32'h0,  4'b0000, 32'h0,        1'b0, 1'b0);
    vt[17] = mk(1'b1, SB,  32'h0000_000F, 32'h0000_005A, 4'b1000, 32'h5AADBEEF, 1'b0, 1'b0);
    vt[18] = mk(1'b0, LW,  32'h0000_0002, 32'h0,        4'b0000, 32'h0,        1'b1, 1'b0);
    vt[19] = mk(1'b0, LHU, 32'h0000_000E, 32'h0,        4'b0000, 32'h5AADBEEF, 1'b0, 1'b0);

    vpost[0] = mk(1'b0, LW, 32'h0000_0008, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0);
    vpost[1] = mk(1'b0, LB, 32'h0000_000D, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0);

    #12;
    chk("rst DMOut",   DMOut,        32'h0);
    chk("rst AddrOut", 32'(AddrOut), 32'h0);
    chk("rst OpOut",   32'(OpOut),   32'h0);
    chk("rst AdEL",    32'(AdEL),    32'h0);
    chk("rst AdES",    32'(AdES),    32'h0);
    chk("rst Busy",    32'(Busy),    32'h1);

    // A misaligned store offered during clear must be dropped silently.
    MemWrite = 1'b1; Op = SW; Addr = 32'h0000_0006; WD = 32'hFFFF_FFFF;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("clr BE",      32'(BE),      32'h0);
    chk("clr AdES",    32'(AdES),    32'h0);
    chk("clr DMOut",   DMOut,        32'h0);
    chk("clr AddrOut", 32'(AddrOut), 32'h2);
    chk("clr OpOut",   32'(OpOut),   32'(SW));
    for (int i = 2; i <= 2**AW; i++) begin
      @(posedge clk);
      #1;
      if (i == 2**AW - 1) chk("clr1 Busy@15", 32'(Busy), 32'd1);
      if (i == 2**AW)     chk("clr1 Busy@16", 32'(Busy), 32'd0);
    end

    for (int k = 0; k < 20; k++) apply(vt[k], $sformatf("v%0d", k));

    // Asynchronous reset while outputs hold live data.
    apply(vt[6], "pre-rst");
    #2 reset = 1'b0;
    #1;
    chk("arst DMOut", DMOut,      32'h0);
    chk("arst OpOut", 32'(OpOut), 32'h0);
    chk("arst Busy",  32'(Busy),  32'h1);

    MemWrite = 1'b0; Op = LH; Addr = 32'h0000_0003; WD = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    chk("mid Busy",    32'(Busy),    32'h1);
    chk("mid AddrOut", 32'(AddrOut), 32'h3);
    chk("mid AdEL",    32'(AdEL),    32'h0);
    chk("mid DMOut",   DMOut,        32'h0);
    #2 reset = 1'b0;
    #1;
    chk("mid-rst AddrOut", 32'(AddrOut), 32'h0);
    chk("mid-rst OpOut",   32'(OpOut),   32'h0);
    chk("mid-rst Busy",    32'(Busy),    32'h1);

    clear_run("clr2");
    apply(vpost[0], "post0");
    apply(vpost[1], "post1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
